// File: rtl/md5_block_feeder.sv
// MD5 message feeder: packs a byte stream into 512-bit little-endian blocks,
// applies MD5 padding and hands each block downstream under valid/ready.
module md5_block_feeder #(
    parameter int unsigned N = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [7:0]   in_data_i,
    input  logic         in_keep_i,
    input  logic         in_last_i,
    output logic         blk_valid_o,
    input  logic         blk_ready_i,
    output logic         blk_last_o,
    output logic [N-1:0] M_o [0:15],
    output logic [63:0]  bit_len_o
);

    typedef enum logic [2:0] {
        StAbsorb,
        StMark,
        StZero,
        StLen,
        StEmit
    } state_e;

    state_e      state_q, state_d;
    state_e      ret_q, ret_d;
    logic [6:0]  pos_q, pos_d;
    logic [6:0]  pos_inc;
    logic [63:0] len_q, len_d;
    logic [63:0] bit_len_q, bit_len_d;
    logic        last_q, last_d;
    logic [N-1:0] m_q [16];
    logic        wr_en;
    logic [7:0]  wr_byte;

    assign pos_inc = pos_q + 7'd1;

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        pos_d     = pos_q;
        len_d     = len_q;
        bit_len_d = bit_len_q;
        last_d    = last_q;
        wr_en     = 1'b0;
        wr_byte   = in_data_i;
        unique case (state_q)
            StAbsorb: begin
                if (in_valid_i) begin
                    if (in_keep_i) begin
                        wr_en = 1'b1;
                        pos_d = pos_inc;
                        len_d = len_q + 64'd1;
                    end
                    if (in_last_i) begin
                        bit_len_d = {len_d[60:0], 3'b000};
                        if (pos_d == 7'd64) begin
                            state_d = StEmit;
                            ret_d   = StMark;
                        end else begin
                            state_d = StMark;
                        end
                    end else if (pos_d == 7'd64) begin
                        state_d = StEmit;
                        ret_d   = StAbsorb;
                    end
                end
            end
            StMark: begin
                wr_en   = 1'b1;
                wr_byte = 8'h80;
                pos_d   = pos_inc;
                if (pos_inc == 7'd56) begin
                    state_d = StLen;
                end else if (pos_inc == 7'd64) begin
                    state_d = StEmit;
                    ret_d   = StZero;
                end else begin
                    state_d = StZero;
                end
            end
            StZero: begin
                // Entered below 56 only when the length fits; above 56 we run to 64.
                wr_en   = 1'b1;
                wr_byte = 8'h00;
                pos_d   = pos_inc;
                if (pos_inc == 7'd56) begin
                    state_d = StLen;
                end else if (pos_inc == 7'd64) begin
                    state_d = StEmit;
                    ret_d   = StZero;
                end
            end
            StLen: begin
                wr_en   = 1'b1;
                wr_byte = bit_len_q[{pos_q[2:0], 3'b000} +: 8];
                pos_d   = pos_inc;
                if (pos_inc == 7'd64) begin
                    state_d = StEmit;
                    ret_d   = StAbsorb;
                    last_d  = 1'b1;
                end
            end
            StEmit: begin
                if (blk_ready_i) begin
                    state_d = ret_q;
                    pos_d   = 7'd0;
                    if (last_q) begin
                        last_d = 1'b0;
                        len_d  = 64'd0;
                    end
                end
            end
            default: state_d = StAbsorb;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StAbsorb;
            ret_q     <= StAbsorb;
            pos_q     <= 7'd0;
            len_q     <= 64'd0;
            bit_len_q <= 64'd0;
            last_q    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                m_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            pos_q     <= pos_d;
            len_q     <= len_d;
            bit_len_q <= bit_len_d;
            last_q    <= last_d;
            if (wr_en) begin
                m_q[pos_q[5:2]][{pos_q[1:0], 3'b000} +: 8] <= wr_byte;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            M_o[i] = m_q[i];
        end
    end

    assign in_ready_o  = (state_q == StAbsorb);
    assign blk_valid_o = (state_q == StEmit);
    assign blk_last_o  = last_q;
    assign bit_len_o   = bit_len_q;

endmodule

// File: tb/tb_md5_block_feeder.sv
// Directed bench for md5_block_feeder; expected blocks come from a reference
// MD5 padding model and are matched against emitted blocks in order.
module tb_md5_block_feeder;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [511:0] words;
        logic         last;
        logic [63:0]  bl;
    } blk_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_keep = 1'b0;
    logic        in_last = 1'b0;
    logic        blk_valid;
    logic        blk_ready = 1'b1;
    logic        blk_last;
    logic [31:0] m [0:15];
    logic [63:0] bit_len;

    int   checks = 0;
    int   errors = 0;
    blk_t sb[$];

    md5_block_feeder #(.N(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .in_keep_i  (in_keep),
        .in_last_i  (in_last),
        .blk_valid_o(blk_valid),
        .blk_ready_i(blk_ready),
        .blk_last_o (blk_last),
        .M_o        (m),
        .bit_len_o  (bit_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] flat_m();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[32*i +: 32] = m[i];
        return f;
    endfunction

    // Reference padding: msg | 0x80 | zeros to 56 mod 64 | 64-bit LE bit length.
    task automatic push_expected(input bq_t msg);
        bq_t         p;
        logic [63:0] bl;
        int          nblk;
        blk_t        e;
        p  = msg;
        bl = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 0; i < 8; i++) p.push_back(bl[8*i +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            for (int k = 0; k < 64; k++) e.words[8*k +: 8] = p[64*b + k];
            e.last = (b == nblk - 1);
            e.bl   = bl;
            sb.push_back(e);
        end
    endtask

    // Inputs change at posedge+1; a beat is accepted at the edge after a high in_ready.
    task automatic beat(input logic keep, input logic [7:0] data, input logic last);
        int n;
        in_valid = 1'b1;
        in_keep  = keep;
        in_data  = data;
        in_last  = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 1000) begin
                chk("beat_timeout", 512'(n), 512'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_keep  = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg(input bq_t msg);
        push_expected(msg);
        if (msg.size() == 0) begin
            beat(1'b0, 8'h00, 1'b1);
        end else begin
            for (int i = 0; i < msg.size(); i++) beat(1'b1, msg[i], i == msg.size() - 1);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk(tag, 512'(sb.size()), 512'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && blk_valid && blk_ready) begin
            blk_t e;
            if (sb.size() == 0) begin
                chk("unexpected_block", 512'd1, 512'd0);
            end else begin
                e = sb.pop_front();
                chk("blk_words", flat_m(), e.words);
                chk("blk_last", 512'(blk_last), 512'(e.last));
                if (e.last) chk("bit_len", 512'(bit_len), 512'(e.bl));
            end
        end
    end

    initial begin
        bq_t  msg;
        blk_t e;

        // Reset state
        #12;
        chk("rst_blk_valid", 512'(blk_valid), 512'd0);
        chk("rst_in_ready", 512'(in_ready), 512'd1);
        chk("rst_blk_last", 512'(blk_last), 512'd0);
        chk("rst_bit_len", 512'(bit_len), 512'd0);
        chk("rst_m", flat_m(), 512'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Empty message
        msg = {};
        send_msg(msg);
        drain("empty_drain");

        // "abc"
        msg = {8'h61, 8'h62, 8'h63};
        send_msg(msg);
        drain("abc_drain");

        // 55 zeros fits one block; 56 zeros needs a length block
        msg = {};
        for (int i = 0; i < 55; i++) msg.push_back(8'h00);
        send_msg(msg);
        drain("z55_drain");
        msg.push_back(8'h00);
        send_msg(msg);
        drain("z56_drain");

        // 64 bytes 0x00..0x3F
        msg = {};
        for (int i = 0; i < 64; i++) msg.push_back(8'(i));
        send_msg(msg);
        drain("b64_drain");

        // Ignored idle beat mid-message, then keep=0 last terminator after "ab"
        msg = {8'h61, 8'h62};
        push_expected(msg);
        beat(1'b1, 8'h61, 1'b0);
        beat(1'b0, 8'hFF, 1'b0);
        beat(1'b1, 8'h62, 1'b0);
        beat(1'b0, 8'h00, 1'b1);
        drain("term_drain");

        // Backpressure: hold the "abc" block for 10 cycles
        blk_ready = 1'b0;
        msg = {8'h61, 8'h62, 8'h63};
        send_msg(msg);
        e = sb[0];
        for (int n = 0; n < 1000 && !blk_valid; n++) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            if (c != 0) @(negedge clk);
            chk("bp_valid", 512'(blk_valid), 512'd1);
            chk("bp_in_ready", 512'(in_ready), 512'd0);
            chk("bp_words", flat_m(), e.words);
        end
        @(posedge clk);
        #1 blk_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_valid_after", 512'(blk_valid), 512'd0);
        chk("bp_in_ready_after", 512'(in_ready), 512'd1);
        chk("bp_sb_empty", 512'(sb.size()), 512'd0);

        // Reset in the middle of LEN
        msg = {8'h61, 8'h62, 8'h63};
        send_msg(msg);
        repeat (56) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        sb.delete();
        chk("mid_rst_blk_valid", 512'(blk_valid), 512'd0);
        chk("mid_rst_in_ready", 512'(in_ready), 512'd1);
        chk("mid_rst_blk_last", 512'(blk_last), 512'd0);
        chk("mid_rst_bit_len", 512'(bit_len), 512'd0);
        chk("mid_rst_m", flat_m(), 512'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        send_msg(msg);
        drain("post_rst_drain");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md5_block_feeder.md
Name: md5_block_feeder

Overview:
- Producer side of the MD5 compression datapath: accepts the message as a byte stream and applies MD5 padding (0x80 marker, zero fill, 64-bit little-endian bit length).
- Packs bytes into 16 little-endian 32-bit words. Presents each complete 512-bit block as M_o[0:15] to the round computation stages.
- Holds each block under a valid/ready handshake. Flags the final block of a message so downstream knows when to finalize the digest.

Parameters:
n  32  word width; only 32 supported (MD5 word size)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous active-high reset
in_valid_i  input  1  byte stream valid
in_ready_o  output  1  feeder can accept a byte this cycle
in_data_i  input  8  message byte
in_keep_i  input  1  1 = in_data_i is a message byte; 0 = no byte, used only with in_last_i to end a message (empty message or end after last byte)
in_last_i  input  1  message ends at this beat
blk_valid_o  output  1  M_o holds a complete block
blk_ready_i  input  1  downstream consumes block
blk_last_o  output  1  current block is the final (length-bearing) block
M_o  output  n x [0:15]  block words, unpacked array
bit_len_o  output  64  message bit length latched at in_last_i (valid while blk_last_o=1)

Behaviour:
- Reset (async, any time, including mid-block or mid-pad):
  - state=ABSORB, pos=0, byte length=0, blk_valid_o=0, blk_last_o=0, bit_len_o=0, M_o all zero, in_ready_o=1.
  - A partially absorbed message is discarded.
- States: ABSORB, MARK, ZERO, LEN, EMIT. pos is a 7-bit byte index within the block, 0..64.
- Byte placement: byte at pos k is written to M_o[k>>2] bits [8*(k%4)+7 : 8*(k%4)]. Every block writes all 64 bytes, so no clearing between blocks.
- ABSORB:
  - in_ready_o=1.
  - On in_valid_i & in_keep_i: write in_data_i at pos, pos+1, length+1 byte.
  - On in_valid_i & in_last_i: latch bit_len_o = (length including this beat's byte)*8, modulo 2^64; pad pending.
  - Next state after in_last_i: MARK, or EMIT if pos reached 64 (resume MARK after the emit).
  - pos reaching 64 without last: EMIT, resume ABSORB.
  - in_valid_i with in_keep_i=0 and in_last_i=0 is ignored.
- MARK: one cycle; write 0x80 at pos, pos+1.
  - If new pos <= 56: go ZERO, or directly LEN when pos==56.
  - If new pos == 64: EMIT, resume ZERO.
  - If new pos in 57..63: ZERO (filling to 64).
- ZERO: write 0x00 per cycle.
  - Stop at pos==56 when the length fits this block: go LEN.
  - Otherwise stop at pos==64: EMIT, then resume ZERO from pos 0 for the length block.
- LEN: 8 cycles; write bit_len_o bytes 0..7 (LSB first) at pos 56..63. Then EMIT with blk_last_o=1.
- EMIT:
  - blk_valid_o=1 and in_ready_o=0.
  - M_o and blk_last_o stay stable until the cycle blk_valid_o & blk_ready_i.
  - On that cycle: blk_valid_o=0 next cycle and pos=0.
  - Resume the saved state. After the last block, resume ABSORB with length=0 and blk_last_o cleared.
- Latency:
  - blk_valid_o rises the cycle after the 64th byte of a block is written.
  - With no stall, a data block reaches EMIT after 64 accepted beats; 1 dead cycle on handshake.
- One byte written per cycle maximum; in_ready_o is 0 in MARK, ZERO, LEN and EMIT.
- blk_ready_i is ignored outside EMIT.

Test Plan:
- Empty message: in_valid_i=1, in_keep_i=0, in_last_i=1 -> one block, blk_last_o=1, M_o[0]=0x00000080, M_o[1..15]=0, bit_len_o=0.
- "abc" (0x61,0x62,0x63, last on 0x63) -> one block, M_o[0]=0x80636261, M_o[1..13]=0, M_o[14]=0x00000018, M_o[15]=0, blk_last_o=1.
- 55 bytes of 0x00 -> single block, M_o[13]=0x80000000, M_o[14]=0x000001B8; 56 bytes -> two blocks, second has M_o[0..13]=0, M_o[14]=0x000001C0, only second blk_last_o=1.
- 64 bytes 0x00..0x3F -> block 1: M_o[0]=0x03020100, M_o[15]=0x3F3E3D3C, blk_last_o=0; block 2: M_o[0]=0x00000080, M_o[14]=0x00000200.
- Backpressure: hold blk_ready_i=0 for 10 cycles in EMIT -> blk_valid_o=1, M_o unchanged, in_ready_o=0 throughout; accept on cycle 11 -> blk_valid_o=0 next cycle, in_ready_o=1.
- Assert rst_i mid-LEN of a message -> outputs immediately to reset values; a following "abc" produces exactly the "abc" block above.
